// File: rtl/skid_buffer.sv
// skid_buffer: two-entry valid/ready buffer that registers both handshake
// directions. A main register drives the consumer side and a skid register
// absorbs the one word that arrives while the consumer is stalled. Because
// input_ready is a flop, no combinational path runs from output_ready back
// to the producer. A stream of one word per cycle passes through while
// output_ready stays high.
module skid_buffer #(
  parameter int unsigned           WORD_WIDTH  = 10,
  parameter logic [WORD_WIDTH-1:0] RESET_VALUE = {WORD_WIDTH{1'b0}}
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  input_valid,
  output logic                  input_ready,
  input  logic [WORD_WIDTH-1:0] input_data,
  output logic                  output_valid,
  input  logic                  output_ready,
  output logic [WORD_WIDTH-1:0] output_data
);

  // Occupancy states: EMPTY holds no word, BUSY holds one word in main,
  // and FULL holds two words with the oldest in main.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t                  state_r;
  logic [WORD_WIDTH-1:0]   main_r;
  logic [WORD_WIDTH-1:0]   skid_r;
  logic                    output_valid_r;
  logic                    input_ready_r;

  logic                    insert_s;
  logic                    remove_s;

  // The handshakes are qualified only by registered flags, so these terms
  // never create an input-to-output combinational path.
  assign insert_s = input_valid & input_ready_r;
  assign remove_s = output_valid_r & output_ready;

  // This block holds the occupancy state machine, the data registers and
  // the registered handshake flags. Reset has priority over clear, and
  // clear has priority over every transition.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r        <= EMPTY;
      main_r         <= RESET_VALUE;
      skid_r         <= RESET_VALUE;
      output_valid_r <= 1'b0;
      input_ready_r  <= 1'b1;
    end else if (clear) begin
      // Any handshake in a clear cycle completes at the ports, but the word
      // is discarded.
      state_r        <= EMPTY;
      main_r         <= RESET_VALUE;
      skid_r         <= RESET_VALUE;
      output_valid_r <= 1'b0;
      input_ready_r  <= 1'b1;
    end else begin
      case (state_r)
        EMPTY: begin
          if (insert_s) begin
            main_r         <= input_data;
            state_r        <= BUSY;
            output_valid_r <= 1'b1;
            input_ready_r  <= 1'b1;
          end else begin
            state_r        <= EMPTY;
            output_valid_r <= 1'b0;
            input_ready_r  <= 1'b1;
          end
        end

        BUSY: begin
          if (insert_s && remove_s) begin
            // The old word leaves while the new word takes its place.
            main_r         <= input_data;
            state_r        <= BUSY;
            output_valid_r <= 1'b1;
            input_ready_r  <= 1'b1;
          end else if (insert_s) begin
            // The consumer stalled, so the new word goes into skid.
            skid_r         <= input_data;
            state_r        <= FULL;
            output_valid_r <= 1'b1;
            input_ready_r  <= 1'b0;
          end else if (remove_s) begin
            // main keeps the departed word; output_valid marks it stale.
            state_r        <= EMPTY;
            output_valid_r <= 1'b0;
            input_ready_r  <= 1'b1;
          end else begin
            state_r        <= BUSY;
            output_valid_r <= 1'b1;
            input_ready_r  <= 1'b1;
          end
        end

        FULL: begin
          // input_ready is low here, so no insert can happen in this state.
          if (remove_s) begin
            main_r         <= skid_r;
            state_r        <= BUSY;
            output_valid_r <= 1'b1;
            input_ready_r  <= 1'b1;
          end else begin
            state_r        <= FULL;
            output_valid_r <= 1'b1;
            input_ready_r  <= 1'b0;
          end
        end

        default: begin
          // An unreachable encoding recovers to a clean empty buffer.
          state_r        <= EMPTY;
          main_r         <= RESET_VALUE;
          skid_r         <= RESET_VALUE;
          output_valid_r <= 1'b0;
          input_ready_r  <= 1'b1;
        end
      endcase
    end
  end

  assign input_ready  = input_ready_r;
  assign output_valid = output_valid_r;
  assign output_data  = main_r;

endmodule

// File: tb/tb_skid_buffer.sv
// Self-checking bench for skid_buffer. The reference model treats the buffer
// as a FIFO of capacity two. Accepted words are pushed onto a queue, and each
// removed word must match the front of the queue. Ready, valid and data are
// predicted from the queue occupancy.
module tb_skid_buffer;

  localparam int unsigned           W  = 10;
  localparam logic [W-1:0]          RV = 10'h000;

  logic         clock;
  logic         reset;
  logic         clear;
  logic         input_valid;
  logic         input_ready;
  logic [W-1:0] input_data;
  logic         output_valid;
  logic         output_ready;
  logic [W-1:0] output_data;

  int checks = 0;
  int errors = 0;
  int removed = 0;

  logic [W-1:0] model_q[$];
  logic         data_is_reset = 1'b1;
  logic         stalled_prev  = 1'b0;
  logic [W-1:0] prev_od       = RV;
  logic         accepted      = 1'b0;

  skid_buffer #(.WORD_WIDTH(W), .RESET_VALUE(RV)) dut (
    .clock        (clock),
    .reset        (reset),
    .clear        (clear),
    .input_valid  (input_valid),
    .input_ready  (input_ready),
    .input_data   (input_data),
    .output_valid (output_valid),
    .output_ready (output_ready),
    .output_data  (output_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Handshakes resolve at the posedge from values that are stable at the
  // negedge. The model therefore predicts and updates at each negedge.
  always @(negedge clock) begin
    int n;
    if (reset) begin
      chk("rst_output_valid", 32'(output_valid), 32'd0);
      chk("rst_input_ready", 32'(input_ready), 32'd1);
      chk("rst_output_data", 32'(output_data), 32'(RV));
      model_q.delete();
      data_is_reset = 1'b1;
      stalled_prev  = 1'b0;
    end else begin
      n = model_q.size();
      chk("input_ready", 32'(input_ready), 32'(n < 2));
      chk("output_valid", 32'(output_valid), 32'(n > 0));
      if (n > 0) chk("output_data", 32'(output_data), 32'(model_q[0]));
      else if (data_is_reset) chk("cleared_data", 32'(output_data), 32'(RV));
      if (stalled_prev) chk("stall_stable", 32'(output_data), 32'(prev_od));
      if (output_valid && output_ready && n > 0) begin
        void'(model_q.pop_front());
        removed++;
      end
      if (input_valid && input_ready) begin
        model_q.push_back(input_data);
        data_is_reset = 1'b0;
      end
      stalled_prev = output_valid & ~output_ready & ~clear;
      prev_od      = output_data;
      if (clear) begin
        model_q.delete();
        data_is_reset = 1'b1;
        stalled_prev  = 1'b0;
      end
    end
  end

  // Each step runs one clock cycle. New inputs are then driven 1 time unit
  // after the posedge. The step also records whether the producer's word
  // was accepted on that edge.
  task automatic step();
    @(negedge clock);
    accepted = input_valid & input_ready;
    @(posedge clock);
    #1;
  endtask

  task automatic drain();
    input_valid  = 1'b0;
    output_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (model_q.size() == 0) break;
      step();
    end
    step();
    chk("drain_empty", 32'(model_q.size()), 32'd0);
  endtask

  initial begin
    int r0;
    int duty_i;
    int duty_o;
    reset = 1'b1; clear = 1'b0; input_valid = 1'b0; output_ready = 1'b0;
    input_data = 10'h000;
    #1;
    chk("init_output_valid", 32'(output_valid), 32'd0);
    chk("init_input_ready", 32'(input_ready), 32'd1);
    chk("init_output_data", 32'(output_data), 32'(RV));
    repeat (2) step();
    reset = 1'b0;

    // Reset mid-stream: fill to FULL, then assert reset between edges.
    input_valid = 1'b1; input_data = 10'h011; step();
    input_data = 10'h022; step();
    input_valid = 1'b0;
    chk("full_input_ready", 32'(input_ready), 32'd0);
    chk("full_output_data", 32'(output_data), 32'h011);
    reset = 1'b1;
    #1;
    chk("async_rst_valid", 32'(output_valid), 32'd0);
    chk("async_rst_ready", 32'(input_ready), 32'd1);
    chk("async_rst_data", 32'(output_data), 32'(RV));
    step();
    reset = 1'b0;
    input_valid = 1'b1; input_data = 10'h033; step();
    input_valid = 1'b0;
    chk("latency_valid", 32'(output_valid), 32'd1);
    chk("latency_data", 32'(output_data), 32'h033);
    drain();

    // Streaming: 0x001 to 0x3FF with output_ready held high.
    output_ready = 1'b1;
    r0 = removed;
    for (int i = 1; i < 1024; i++) begin
      input_valid = 1'b1;
      input_data  = 10'(i);
      step();
      chk("stream_accept", 32'(accepted), 32'd1);
    end
    drain();
    chk("stream_count", 32'(removed - r0), 32'd1023);

    // Backpressure: three back-to-back words while the consumer is stalled.
    output_ready = 1'b0;
    input_valid = 1'b1; input_data = 10'h0A0; step();
    input_data = 10'h0A1; step();
    input_data = 10'h0A2; step();
    chk("bp_a2_refused", 32'(accepted), 32'd0);
    chk("bp_input_ready", 32'(input_ready), 32'd0);
    chk("bp_head", 32'(output_data), 32'h0A0);
    output_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (accepted) break;
    end
    chk("bp_a2_accepted", 32'(accepted), 32'd1);
    drain();

    // Flow-through: hold one word, then insert and remove together 50 times.
    output_ready = 1'b0;
    input_valid = 1'b1; input_data = 10'h100; step();
    output_ready = 1'b1;
    for (int k = 0; k < 50; k++) begin
      input_data = 10'(10'h200 + k);
      step();
      chk("flow_accept", 32'(accepted), 32'd1);
    end
    drain();

    // Clear priority: assert clear in FULL with output_ready high.
    output_ready = 1'b0;
    input_valid = 1'b1; input_data = 10'h055; step();
    input_data = 10'h066; step();
    input_valid = 1'b0;
    clear = 1'b1; output_ready = 1'b1; step();
    clear = 1'b0;
    chk("clear_valid", 32'(output_valid), 32'd0);
    chk("clear_ready", 32'(input_ready), 32'd1);
    chk("clear_data", 32'(output_data), 32'(RV));
    repeat (3) step();
    chk("clear_no_replay", 32'(output_valid), 32'd0);

    // Random traffic. Each 500-cycle phase sets new valid/ready duty cycles,
    // and a rare clear is included. The producer holds a word until it is
    // accepted.
    duty_i = 50; duty_o = 50;
    accepted = 1'b0;
    input_valid = 1'b0;
    for (int c = 0; c < 10000; c++) begin
      if (c % 500 == 0) begin
        duty_i = int'($urandom_range(30, 90));
        duty_o = int'($urandom_range(30, 90));
      end
      clear        = ($urandom_range(0, 999) == 0);
      output_ready = (int'($urandom_range(0, 99)) < duty_o);
      if (!input_valid || accepted) begin
        input_valid = (int'($urandom_range(0, 99)) < duty_i);
        input_data  = 10'($urandom);
      end
      step();
    end
    clear = 1'b0;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
